// File: rtl/atp_pkg.sv
// Shared definitions for the ATP payout path: amount width, denomination table
// and the change-dispenser state encoding.
package atp_pkg;

  localparam int AMTW   = 10;
  localparam int NDENOM = 7;
  localparam int SELW   = 3;

  localparam logic [SELW-1:0] IDX_100     = 3'd0;
  localparam logic [SELW-1:0] IDX_50      = 3'd1;
  localparam logic [SELW-1:0] IDX_20      = 3'd2;
  localparam logic [SELW-1:0] IDX_10      = 3'd3;
  localparam logic [SELW-1:0] IDX_5       = 3'd4;
  localparam logic [SELW-1:0] IDX_2       = 3'd5;
  localparam logic [SELW-1:0] IDX_1       = 3'd6;
  localparam logic [SELW-1:0] IDX_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_DONE   = 2'd3
  } atp_state_e;

  // Face value of a denomination index; the illegal index is worth nothing.
  function automatic logic [AMTW-1:0] denom_value(input logic [SELW-1:0] idx);
    case (idx)
      IDX_100: return 10'd100;
      IDX_50:  return 10'd50;
      IDX_20:  return 10'd20;
      IDX_10:  return 10'd10;
      IDX_5:   return 10'd5;
      IDX_2:   return 10'd2;
      IDX_1:   return 10'd1;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/atp_denom_select.sv
// Greedy picker: the lowest index (largest note) that still fits in the
// remaining amount and has stock on hand.
module atp_denom_select
  import atp_pkg::*;
(
  input  logic [AMTW-1:0]   remaining,
  input  logic [NDENOM-1:0] avail,
  output logic              found,
  output logic [SELW-1:0]   index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = 0; i < NDENOM; i++) begin
      if (!found && avail[i] && (denom_value(SELW'(i)) <= remaining)) begin
        found = 1'b1;
        index = SELW'(i);
      end
    end
  end

endmodule

// File: rtl/atp_change_dispenser.sv
// Returns an excess amount as notes/coins, one per valid/ack transfer, tracking
// per-denomination stock and reporting any amount that could not be paid out.
module atp_change_dispenser
  import atp_pkg::*;
#(
  parameter int STOCKW     = 8,
  parameter int STOCK_INIT = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AMTW-1:0]   amt,
  input  logic              stop,
  output logic              note_val,
  output logic [SELW-1:0]   note_sel,
  input  logic              note_ack,
  input  logic              refill,
  input  logic [SELW-1:0]   refill_sel,
  input  logic [STOCKW-1:0] refill_cnt,
  output logic              busy,
  output logic              done,
  output logic [AMTW-1:0]   short_amt,
  output logic [1:0]        dbg_state
);

  // Handshake: note_val rises in ISSUE and note_sel stays frozen until a cycle
  // with note_val && note_ack, which is the single transfer of that note.

  atp_state_e        state, state_n;
  logic [AMTW-1:0]   remaining;
  logic [AMTW-1:0]   cur_val;
  logic [STOCKW-1:0] stock [NDENOM];
  logic [NDENOM-1:0] avail;
  logic              pick_found;
  logic [SELW-1:0]   pick_idx;
  logic              xfer;
  logic [STOCKW:0]   refill_sum;
  logic [STOCKW-1:0] refill_new;

  always_comb begin
    for (int i = 0; i < NDENOM; i++) avail[i] = (stock[i] != '0);
  end

  atp_denom_select u_select (
    .remaining (remaining),
    .avail     (avail),
    .found     (pick_found),
    .index     (pick_idx)
  );

  assign cur_val   = denom_value(note_sel);
  assign xfer      = (state == ST_ISSUE) && note_ack;
  assign note_val  = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  // Saturating refill so a large top-up never wraps the counter.
  always_comb begin
    refill_sum = {1'b0, stock[refill_sel]} + {1'b0, refill_cnt};
    refill_new = refill_sum[STOCKW] ? '1 : refill_sum[STOCKW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (start) state_n = ST_SELECT;
      ST_SELECT: state_n = (stop || !pick_found) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: begin
        if (xfer)      state_n = stop ? ST_DONE : ST_SELECT;
        else if (stop) state_n = ST_DONE;
      end
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      note_sel  <= '0;
      short_amt <= '0;
      for (int i = 0; i < NDENOM; i++) stock[i] <= STOCKW'(STOCK_INIT);
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= amt;
            short_amt <= '0;
          end
          if (refill && (refill_sel != IDX_ILLEGAL)) stock[refill_sel] <= refill_new;
        end
        ST_SELECT: begin
          // With nothing left to pay, remaining is 0 and so is the shortfall.
          if (stop || !pick_found) short_amt <= remaining;
          else                     note_sel  <= pick_idx;
        end
        ST_ISSUE: begin
          if (xfer) begin
            remaining       <= remaining - cur_val;
            stock[note_sel] <= stock[note_sel] - STOCKW'(1);
            if (stop) short_amt <= remaining - cur_val;
          end else if (stop) begin
            short_amt <= remaining;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atp_change_dispenser.sv
// Directed bench for the change dispenser: one instance with full stock and one
// with a single unit per denomination, checked through an expected-event queue.
module tb_atp_change_dispenser;

  logic       clk;
  logic       rst_v        [2];
  logic       start_v      [2];
  logic [9:0] amt_v        [2];
  logic       stop_v       [2];
  logic       note_val_v   [2];
  logic [2:0] note_sel_v   [2];
  logic       ack_v        [2];
  logic       refill_v     [2];
  logic [2:0] refill_sel_v [2];
  logic [7:0] refill_cnt_v [2];
  logic       busy_v       [2];
  logic       done_v       [2];
  logic [9:0] short_v      [2];
  logic [1:0] state_v      [2];

  int total = 0;
  int bad   = 0;

  // Event word: [12] instance, [11] 1 = done / 0 = note, [9:0] short_amt or note_sel.
  logic [12:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  function automatic logic [12:0] mk(input int inst, input int kind, input int payload);
    logic [31:0] i32, k32, p32;
    i32 = inst; k32 = kind; p32 = payload;
    return {i32[0], k32[0], 1'b0, p32[9:0]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_event(input int inst, input int kind, input int payload);
    logic [12:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event inst=%0d kind=%0d value=%0d", inst, kind, payload);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("event_inst%0d_%s", inst, (kind == 1) ? "done" : "note"),
          int'(mk(inst, kind, payload)), int'(e));
    end
  endtask

  function automatic int stk(input int inst, input int idx);
    if (inst == 0) return int'(gen_dut[0].dut.stock[idx]);
    else           return int'(gen_dut[1].dut.stock[idx]);
  endfunction

  // ---------------- DUTs and monitors ----------------
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    atp_change_dispenser #(
      .STOCKW     (8),
      .STOCK_INIT ((g == 0) ? 20 : 1)
    ) dut (
      .clk        (clk),
      .rst        (rst_v[g]),
      .start      (start_v[g]),
      .amt        (amt_v[g]),
      .stop       (stop_v[g]),
      .note_val   (note_val_v[g]),
      .note_sel   (note_sel_v[g]),
      .note_ack   (ack_v[g]),
      .refill     (refill_v[g]),
      .refill_sel (refill_sel_v[g]),
      .refill_cnt (refill_cnt_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .short_amt  (short_v[g]),
      .dbg_state  (state_v[g])
    );

    always @(negedge clk) begin
      if (!rst_v[g] && note_val_v[g] && ack_v[g]) check_event(g, 0, int'(note_sel_v[g]));
      if (!rst_v[g] && done_v[g])                 check_event(g, 1, int'(short_v[g]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // poke_kind: 0 none, 1 start while busy, 2 refill while busy.
  task automatic run(input int inst, input int a, input int exp_cyc,
                     input int poke_cyc, input int poke_kind);
    int cyc;
    tick();
    amt_v[inst]   = 10'(a);
    start_v[inst] = 1'b1;
    cyc = 0;
    forever begin
      tick();
      start_v[inst]  = 1'b0;
      refill_v[inst] = 1'b0;
      cyc++;
      if (done_v[inst]) break;
      if (cyc > 300) begin
        chk("done_timeout", cyc, exp_cyc);
        return;
      end
      if (cyc == poke_cyc && poke_kind == 1) begin
        start_v[inst] = 1'b1;
        amt_v[inst]   = 10'd100;
      end
      if (cyc == poke_cyc && poke_kind == 2) begin
        refill_v[inst]     = 1'b1;
        refill_sel_v[inst] = 3'd1;
        refill_cnt_v[inst] = 8'd5;
      end
    end
    chk($sformatf("done_latency_amt%0d", a), cyc, exp_cyc);
    tick();
  endtask

  task automatic do_refill(input int inst, input int sel, input int cnt);
    tick();
    refill_v[inst]     = 1'b1;
    refill_sel_v[inst] = 3'(sel);
    refill_cnt_v[inst] = 8'(cnt);
    tick();
    refill_v[inst] = 1'b0;
  endtask

  task automatic start_only(input int inst, input int a);
    tick();
    amt_v[inst]   = 10'(a);
    start_v[inst] = 1'b1;
    tick();
    start_v[inst] = 1'b0;
  endtask

  task automatic wait_note(input int inst);
    int n;
    n = 0;
    while (!note_val_v[inst] && n < 50) begin
      tick();
      n++;
    end
    if (!note_val_v[inst]) chk("note_val_timeout", 0, 1);
  endtask

  task automatic wait_done(input int inst);
    int n;
    n = 0;
    while (!done_v[inst] && n < 50) begin
      tick();
      n++;
    end
    chk("wait_done", int'(done_v[inst]), 1);
    tick();
  endtask

  task automatic push_notes(input int inst, input int sels[$]);
    foreach (sels[i]) exp_q.push_back(mk(inst, 0, sels[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b1; start_v[i] = 1'b0; amt_v[i] = '0; stop_v[i] = 1'b0;
      ack_v[i] = 1'b1; refill_v[i] = 1'b0; refill_sel_v[i] = '0; refill_cnt_v[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) rst_v[i] = 1'b0;

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy%0d", i),     int'(busy_v[i]),     0);
      chk($sformatf("rst_note_val%0d", i), int'(note_val_v[i]), 0);
      chk($sformatf("rst_note_sel%0d", i), int'(note_sel_v[i]), 0);
      chk($sformatf("rst_done%0d", i),     int'(done_v[i]),     0);
      chk($sformatf("rst_short%0d", i),    int'(short_v[i]),    0);
      chk($sformatf("rst_state%0d", i),    int'(state_v[i]),    0);
    end
    for (int d = 0; d < 7; d++) begin
      chk($sformatf("rst_stock0_%0d", d), stk(0, d), 20);
      chk($sformatf("rst_stock1_%0d", d), stk(1, d), 1);
    end

    // amt=45, full stock: 20, 20, 5 and done 8 cycles after start.
    push_notes(0, '{2, 2, 4});
    exp_q.push_back(mk(0, 1, 0));
    run(0, 45, 8, 0, 0);
    chk("stock0_20_after45", stk(0, 2), 18);
    chk("stock0_5_after45",  stk(0, 4), 19);

    // A start during the transaction is ignored.
    push_notes(0, '{2, 2, 4});
    exp_q.push_back(mk(0, 1, 0));
    run(0, 45, 8, 3, 1);
    chk("stock0_20_after_busy_start", stk(0, 2), 16);
    chk("busy_after_ignored_start", int'(busy_v[0]), 0);

    // amt=0: done two cycles after start, no note.
    exp_q.push_back(mk(0, 1, 0));
    run(0, 0, 2, 0, 0);

    // amt=7 with ack held low: note_sel=4 held while waiting.
    ack_v[0] = 1'b0;
    push_notes(0, '{4, 5});
    exp_q.push_back(mk(0, 1, 0));
    start_only(0, 7);
    wait_note(0);
    chk("ackdelay_sel", int'(note_sel_v[0]), 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ackdelay_val_%0d", k), int'(note_val_v[0]), 1);
      chk($sformatf("ackdelay_sel_%0d", k), int'(note_sel_v[0]), 4);
    end
    ack_v[0] = 1'b1;
    wait_done(0);
    chk("ackdelay_short", int'(short_v[0]), 0);

    // Reset in the middle of ISSUE.
    ack_v[0] = 1'b0;
    start_only(0, 45);
    wait_note(0);
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    chk("midrst_busy",     int'(busy_v[0]),     0);
    chk("midrst_note_val", int'(note_val_v[0]), 0);
    for (int d = 0; d < 7; d++) chk($sformatf("midrst_stock_%0d", d), stk(0, d), 20);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
        if (done_v[0]) seen++;
        tick();
      end
      chk("midrst_no_done", seen, 0);
    end
    ack_v[0] = 1'b1;

    // STOCK_INIT=1, amt=300: one of each, 112 short.
    push_notes(1, '{0, 1, 2, 3, 4, 5, 6});
    exp_q.push_back(mk(1, 1, 112));
    run(1, 300, 16, 0, 0);
    for (int d = 0; d < 7; d++) chk($sformatf("drained_stock_%0d", d), stk(1, d), 0);
    tick();
    tick();
    chk("short_held_idle", int'(short_v[1]), 112);

    // Refill 100s, then amt=250 gives 100, 100, short 50; busy refill ignored.
    do_refill(1, 0, 3);
    chk("refill_stock0", stk(1, 0), 3);
    push_notes(1, '{0, 0});
    exp_q.push_back(mk(1, 1, 50));
    run(1, 250, 6, 2, 2);
    chk("refill250_stock0", stk(1, 0), 1);
    chk("busy_refill_ignored", stk(1, 1), 0);

    // Saturating refill and ignored index 7.
    do_refill(1, 6, 250);
    do_refill(1, 6, 10);
    chk("refill_saturate", stk(1, 6), 255);
    do_refill(1, 7, 9);
    chk("refill_idx7_stock0", stk(1, 0), 1);

    // Use the last 100, then refill 50s.
    exp_q.push_back(mk(1, 0, 0));
    exp_q.push_back(mk(1, 1, 0));
    run(1, 100, 4, 0, 0);
    chk("stock0_empty", stk(1, 0), 0);
    do_refill(1, 1, 2);

    // Stop during first ISSUE without ack: whole 100 is short.
    ack_v[1] = 1'b0;
    exp_q.push_back(mk(1, 1, 100));
    start_only(1, 100);
    wait_note(1);
    chk("stop_sel", int'(note_sel_v[1]), 1);
    stop_v[1] = 1'b1;
    tick();
    stop_v[1] = 1'b0;
    chk("stop_done",  int'(done_v[1]),  1);
    chk("stop_short", int'(short_v[1]), 100);
    tick();
    chk("stop_stock50", stk(1, 1), 2);

    // Stop together with ack: the 50 is paid first, 50 short.
    exp_q.push_back(mk(1, 0, 1));
    exp_q.push_back(mk(1, 1, 50));
    start_only(1, 100);
    wait_note(1);
    ack_v[1]  = 1'b1;
    stop_v[1] = 1'b1;
    tick();
    stop_v[1] = 1'b0;
    chk("stopack_done",  int'(done_v[1]),  1);
    chk("stopack_short", int'(short_v[1]), 50);
    tick();
    chk("stopack_stock50", stk(1, 1), 1);
    chk("stopack_idle",    int'(busy_v[1]), 0);

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
